// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter
//   Shares the external 1M x 16 audio SRAM between the recorder (writes) and
//   the playback DSP (reads). Each granted access runs SETUP -> ACCESS
//   (ACCESS_CYCLES strobe cycles) -> ACK. Ties are arbitrated round-robin.
//   Recorder writes into the opening-clip region [PROT_LO, PROT_HI] are
//   rejected without touching the SRAM.
//
//   Build option: define SRAM_ARB_WRITE_PRIO_EN to give the recorder fixed
//   priority on ties instead of round-robin.
//
//   Ports
//     i_clk, i_rst_n          clock, async active-low reset
//     i_rec_req/addr/wdata    recorder write request (level, held until ack)
//     o_rec_ack, o_rec_err    write done / rejected pulses
//     i_dsp_req/addr          DSP read request (level, held until ack)
//     o_dsp_ack, o_dsp_rdata  read done pulse, registered read data
//     o_sram_*                SRAM address/data/strobes (strobes active-low)
//     i_sram_rdata            sampled DQ bus
//     o_sram_dq_oe            1 = top level drives DQ with o_sram_wdata
//     o_busy                  an access is in progress
//
//   state    | meaning
//   S_IDLE   | arbitrate requests, latch the granted access
//   S_SETUP  | address/CE set up ahead of the strobe
//   S_ACCESS | OE_n or WE_n low for ACCESS_CYCLES cycles
//   S_ACK    | strobes released, ack pulse to the granted requester
module sram_access_arbiter #(
  parameter int          ACCESS_CYCLES = 2,
  parameter logic [19:0] PROT_LO       = 20'h143C0,
  parameter logic [19:0] PROT_HI       = 20'd164479
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rec_req,
  input  logic [19:0] i_rec_addr,
  input  logic [15:0] i_rec_wdata,
  output logic        o_rec_ack,
  output logic        o_rec_err,
  input  logic        i_dsp_req,
  input  logic [19:0] i_dsp_addr,
  output logic        o_dsp_ack,
  output logic [15:0] o_dsp_rdata,
  output logic [19:0] o_sram_addr,
  output logic [15:0] o_sram_wdata,
  input  logic [15:0] i_sram_rdata,
  output logic        o_sram_dq_oe,
  output logic        o_sram_ce_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_we_n,
  output logic        o_sram_lb_n,
  output logic        o_sram_ub_n,
  output logic        o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_ACK} state_t;

  localparam logic [3:0] ACC_LAST = 4'(ACCESS_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        is_wr_q, is_wr_d;
  logic        err_q, err_d;
  logic        last_rec_q, last_rec_d;  // 1: last grant went to the recorder
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        dq_oe_q, dq_oe_d;

  logic grant_rec, grant_dsp, in_prot, active_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    is_wr_d    = is_wr_q;
    err_d      = err_q;
    last_rec_d = last_rec_q;

`ifdef SRAM_ARB_WRITE_PRIO_EN
    grant_rec = i_rec_req;
`else
    grant_rec = i_rec_req && (!i_dsp_req || !last_rec_q);
`endif
    grant_dsp = i_dsp_req && !grant_rec;
    in_prot   = (i_rec_addr >= PROT_LO) && (i_rec_addr <= PROT_HI);

    unique case (state_q)
      S_IDLE: begin
        if (grant_rec) begin
          is_wr_d    = 1'b1;
          addr_d     = i_rec_addr;
          wdata_d    = i_rec_wdata;
          last_rec_d = 1'b1;
          err_d      = in_prot;
          state_d    = in_prot ? S_ACK : S_SETUP;
        end else if (grant_dsp) begin
          is_wr_d    = 1'b0;
          addr_d     = i_dsp_addr;
          last_rec_d = 1'b0;
          err_d      = 1'b0;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = ACC_LAST;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!is_wr_q) rdata_d = i_sram_rdata;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered from the next state so the pins never glitch.
    // A rejected write passes through S_ACK with the SRAM left deselected.
    active_d = (state_d != S_IDLE) && !err_d;
    ce_n_d   = !active_d;
    oe_n_d   = !((state_d == S_ACCESS) && !is_wr_d);
    we_n_d   = !((state_d == S_ACCESS) && is_wr_d);
    dq_oe_d  = active_d && is_wr_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 20'd0;
      wdata_q    <= 16'd0;
      rdata_q    <= 16'd0;
      is_wr_q    <= 1'b0;
      err_q      <= 1'b0;
      last_rec_q <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      dq_oe_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      is_wr_q    <= is_wr_d;
      err_q      <= err_d;
      last_rec_q <= last_rec_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      dq_oe_q    <= dq_oe_d;
    end
  end

  assign o_rec_ack    = (state_q == S_ACK) && is_wr_q;
  assign o_rec_err    = o_rec_ack && err_q;
  assign o_dsp_ack    = (state_q == S_ACK) && !is_wr_q;
  assign o_dsp_rdata  = rdata_q;
  assign o_sram_addr  = addr_q;
  assign o_sram_wdata = wdata_q;
  assign o_sram_dq_oe = dq_oe_q;
  assign o_sram_ce_n  = ce_n_q;
  assign o_sram_oe_n  = oe_n_q;
  assign o_sram_we_n  = we_n_q;
  assign o_sram_lb_n  = 1'b0;
  assign o_sram_ub_n  = 1'b0;
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sram_access_arbiter.sv
module tb_sram_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rec_req = 1'b0;
  logic [19:0] rec_addr = 20'd0;
  logic [15:0] rec_wdata = 16'd0;
  logic        rec_ack, rec_err;
  logic        dsp_req = 1'b0;
  logic [19:0] dsp_addr = 20'd0;
  logic        dsp_ack;
  logic [15:0] dsp_rdata;
  logic [19:0] sram_addr;
  logic [15:0] sram_wdata, sram_rdata;
  logic        dq_oe, ce_n, oe_n, we_n, lb_n, ub_n, busy;

  sram_access_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rec_req(rec_req), .i_rec_addr(rec_addr), .i_rec_wdata(rec_wdata),
    .o_rec_ack(rec_ack), .o_rec_err(rec_err),
    .i_dsp_req(dsp_req), .i_dsp_addr(dsp_addr),
    .o_dsp_ack(dsp_ack), .o_dsp_rdata(dsp_rdata),
    .o_sram_addr(sram_addr), .o_sram_wdata(sram_wdata), .i_sram_rdata(sram_rdata),
    .o_sram_dq_oe(dq_oe), .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n),
    .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // SRAM model (low address byte only) and per-cycle strobe counters.
  logic [15:0] mem [0:255];
  int we_cyc = 0, oe_cyc = 0, dqoe_cyc = 0, ce_cyc = 0, rec_acks = 0, dsp_acks = 0;

  assign sram_rdata = (!ce_n && !oe_n) ? mem[sram_addr[7:0]] : 16'hDEAD;

  always @(posedge clk) begin
    if (!ce_n && !we_n) mem[sram_addr[7:0]] <= sram_wdata;
    if (!we_n)  we_cyc   <= we_cyc + 1;
    if (!oe_n)  oe_cyc   <= oe_cyc + 1;
    if (dq_oe)  dqoe_cyc <= dqoe_cyc + 1;
    if (!ce_n)  ce_cyc   <= ce_cyc + 1;
    if (rec_ack) rec_acks <= rec_acks + 1;
    if (dsp_ack) dsp_acks <= dsp_acks + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; waits for the ack of one port, dropping its request
  // in the cycle the ack is seen. lat counts negedges, -1 on timeout.
  task automatic wait_ack(input bit is_dsp, output int lat, output logic err);
    bit done = 0;
    lat = -1;
    err = 1'b0;
    for (int n = 1; n <= 40 && !done; n++) begin
      @(negedge clk);
      if (is_dsp ? dsp_ack : rec_ack) begin
        lat  = n;
        err  = rec_err;
        done = 1;
        if (is_dsp) dsp_req = 1'b0; else rec_req = 1'b0;
      end
    end
  endtask

  task automatic do_write(input string tag, input logic [19:0] a, input logic [15:0] d,
                          input int exp_lat, input logic exp_err,
                          input int exp_we, input int exp_dqoe);
    int lat, we0, dq0, ce0;
    logic err;
    we0 = we_cyc; dq0 = dqoe_cyc; ce0 = ce_cyc;
    rec_addr = a; rec_wdata = d; rec_req = 1'b1;
    wait_ack(1'b0, lat, err);
    @(negedge clk);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    check({tag, "_we_cycles"}, we_cyc - we0, exp_we);
    check({tag, "_dqoe_cycles"}, dqoe_cyc - dq0, exp_dqoe);
    if (exp_err) check({tag, "_ce_cycles"}, ce_cyc - ce0, 0);
    else         check({tag, "_mem"}, {16'd0, mem[a[7:0]]}, {16'd0, d});
  endtask

  int lat, we0, oe0, ra0, da0;
  logic err;
  int order [0:7];
  int nacks;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'h1234;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ce_n", ce_n, 1);
    check("rst_oe_n", oe_n, 1);
    check("rst_we_n", we_n, 1);
    check("rst_dq_oe", dq_oe, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_rdata", dsp_rdata, 0);
    check("rst_acks", {rec_ack, rec_err, dsp_ack}, 0);
    check("rst_byte_en", {lb_n, ub_n}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single DSP read.
    we0 = we_cyc; oe0 = oe_cyc;
    dsp_addr = 20'h00010; dsp_req = 1'b1;
    wait_ack(1'b1, lat, err);
    check("rd_rdata", dsp_rdata, 16'h1234);
    @(negedge clk);
    check("rd_lat", lat, 4);
    check("rd_oe_cycles", oe_cyc - oe0, 2);
    check("rd_we_cycles", we_cyc - we0, 0);
    check("rd_busy_after", busy, 0);

    // Writes: normal, protected edges, just-outside edges.
    do_write("wr",      20'h00020, 16'hBEEF, 4, 1'b0, 2, 4);
    do_write("prot_lo", 20'h143C0, 16'h1111, 1, 1'b1, 0, 0);
    do_write("prot_hi", 20'd164479, 16'h2222, 1, 1'b1, 0, 0);
    do_write("below",   20'h143BF, 16'h3333, 4, 1'b0, 2, 4);
    do_write("above",   20'd164480, 16'h4444, 4, 1'b0, 2, 4);

    // Reset in the middle of a write, with a DSP request waiting.
    ra0 = rec_acks;
    rec_addr = 20'h00040; rec_wdata = 16'h5A5A; rec_req = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_we_low", we_n, 0);
    dsp_addr = 20'h00010; dsp_req = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("abort_strobes", {ce_n, oe_n, we_n, dq_oe}, 4'b1110);
    check("abort_busy", busy, 0);
    rec_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ack(1'b1, lat, err);
    check("abort_dsp_rdata", dsp_rdata, 16'h1234);
    @(negedge clk);
    check("abort_dsp_lat", lat, 4);
    check("abort_no_rec_ack", rec_acks - ra0, 0);

    // DSP drops request and changes address mid-access.
    da0 = dsp_acks; oe0 = oe_cyc;
    dsp_addr = 20'h00010; dsp_req = 1'b1;
    repeat (2) @(negedge clk);
    check("drop_addr", sram_addr, 20'h00010);
    dsp_req = 1'b0; dsp_addr = 20'h00020;
    wait_ack(1'b1, lat, err);
    check("drop_lat", lat, 2);
    check("drop_rdata", dsp_rdata, 16'h1234);
    repeat (8) @(negedge clk);
    check("drop_one_ack", dsp_acks - da0, 1);
    check("drop_one_access", oe_cyc - oe0, 2);

    // Both requests held: 8 accesses.
    rec_addr = 20'h00030; rec_wdata = 16'h5555; rec_req = 1'b1;
    dsp_addr = 20'h00010; dsp_req = 1'b1;
    nacks = 0;
    for (int n = 0; n < 120 && nacks < 8; n++) begin
      @(negedge clk);
      if (rec_ack || dsp_ack) begin
        order[nacks] = rec_ack ? 1 : 0;
        nacks++;
        if (nacks == 8) begin rec_req = 1'b0; dsp_req = 1'b0; end
      end
    end
    check("tie_count", nacks, 8);
    for (int i = 0; i < 8; i++) begin
`ifdef SRAM_ARB_WRITE_PRIO_EN
      check($sformatf("tie_grant%0d", i), order[i], 1);
`else
      check($sformatf("tie_grant%0d", i), order[i], (i % 2 == 0) ? 1 : 0);
`endif
    end
    repeat (4) @(negedge clk);
    check("tie_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
